// File: rtl/energy_det_pkg.sv
// energy_det_pkg: shared widths and types for the sliding-window energy detector.
// Build option ENERGY_DET_HYST_EN enables the two-threshold detect (see energy_window_det).
package energy_det_pkg;

  localparam int DATA_W   = 8;
  localparam int WIN_LOG2 = 4;
  localparam int SQ_W     = 2*DATA_W-1;
  localparam int ACC_W    = SQ_W+WIN_LOG2;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef logic signed [DATA_W-1:0] sample_t;
  typedef logic [ACC_W-1:0]         energy_t;

endpackage

// File: rtl/energy_win_buf.sv
// energy_win_buf: circular buffer of squared samples.
// The registered read returns the pre-write contents of the addressed slot.
module energy_win_buf
  import energy_det_pkg::*;
#(
  parameter int AW = WIN_LOG2,
  parameter int DW = SQ_W
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [1<<AW];

  always_ff @(posedge clk) begin
    if (we) begin
      rdata     <= mem[addr];
      mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/energy_window_det.sv
// energy_window_det: squares samples, sums the last 2^WIN_LOG2, compares to thresh.
// Define ENERGY_DET_HYST_EN to add thresh_lo and a hysteretic detect.
module energy_window_det #(
  parameter int  DATA_W   = energy_det_pkg::DATA_W,
  parameter int  WIN_LOG2 = energy_det_pkg::WIN_LOG2,
  localparam int SQ_W     = 2*DATA_W-1,
  localparam int ACC_W    = SQ_W+WIN_LOG2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enb,
  input  logic signed [DATA_W-1:0] din,
  input  logic                     din_vld,
  input  logic [ACC_W-1:0]         thresh,
`ifdef ENERGY_DET_HYST_EN
  input  logic [ACC_W-1:0]         thresh_lo,
`endif
  output logic [ACC_W-1:0]         energy_out,
  output logic                     energy_vld,
  output logic                     detect,
  output logic                     win_full
);

  import energy_det_pkg::*;

  localparam int DEPTH = 1 << WIN_LOG2;

  logic                accept;
  logic [DATA_W-1:0]   mag;
  logic [SQ_W-1:0]     mag_x;
  logic [SQ_W-1:0]     sq;
  state_t              state;
  logic [WIN_LOG2-1:0] wr_ptr;
  logic [WIN_LOG2-1:0] fill_cnt;
  logic                last_fill;

  logic                s1_vld;
  logic                s1_fill;
  logic                s1_rep;
  logic [SQ_W-1:0]     s1_sq;
  logic [ACC_W-1:0]    s1_thr;
`ifdef ENERGY_DET_HYST_EN
  logic [ACC_W-1:0]    s1_thr_lo;
`endif
  logic [SQ_W-1:0]     old_rd;
  logic [SQ_W-1:0]     old_eff;
  logic [ACC_W-1:0]    sum;
  logic [ACC_W-1:0]    new_sum;
  logic                det_next;

  assign accept = enb && din_vld;

  // |-128| wraps to 8'h80, which reads correctly as unsigned 128
  assign mag   = din[DATA_W-1] ? -din : din;
  assign mag_x = SQ_W'(mag);
  assign sq    = mag_x * mag_x;

  assign last_fill = (fill_cnt == WIN_LOG2'(DEPTH-1));

  energy_win_buf #(
    .AW (WIN_LOG2),
    .DW (SQ_W)
  ) u_buf (
    .clk   (clk),
    .we    (accept),
    .addr  (wr_ptr),
    .wdata (sq),
    .rdata (old_rd)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= FILL;
      wr_ptr   <= '0;
      fill_cnt <= '0;
      s1_vld   <= 1'b0;
      s1_fill  <= 1'b0;
      s1_rep   <= 1'b0;
      s1_sq    <= '0;
      s1_thr   <= '0;
`ifdef ENERGY_DET_HYST_EN
      s1_thr_lo <= '0;
`endif
    end else if (enb) begin
      s1_vld <= din_vld;
      if (din_vld) begin
        s1_sq   <= sq;
        s1_thr  <= thresh;
`ifdef ENERGY_DET_HYST_EN
        s1_thr_lo <= thresh_lo;
`endif
        s1_fill <= (state == FILL);
        s1_rep  <= (state == RUN) || last_fill;
        wr_ptr  <= wr_ptr + WIN_LOG2'(1);
        if (state == FILL) begin
          fill_cnt <= fill_cnt + WIN_LOG2'(1);
          if (last_fill) state <= RUN;
        end
      end
    end
  end

  // slots read while filling hold stale data from before reset
  assign old_eff = s1_fill ? '0 : old_rd;
  assign new_sum = sum + ACC_W'(s1_sq) - ACC_W'(old_eff);

`ifdef ENERGY_DET_HYST_EN
  always_comb begin
    det_next = detect;
    if (new_sum > s1_thr)
      det_next = 1'b1;
    else if (new_sum < s1_thr_lo)
      det_next = 1'b0;
  end
`else
  assign det_next = (new_sum > s1_thr);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      sum        <= '0;
      energy_out <= '0;
      energy_vld <= 1'b0;
      detect     <= 1'b0;
      win_full   <= 1'b0;
    end else if (enb) begin
      energy_vld <= s1_vld && s1_rep;
      if (s1_vld) begin
        sum <= new_sum;
        if (s1_rep) begin
          energy_out <= new_sum;
          detect     <= det_next;
          win_full   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/energy_window_det.md
Name: energy_window_det

Overview:
- Sliding-window energy detector; sits directly downstream of the flip_t stage and consumes its 8-bit sample stream.
- Squares each signed sample and keeps a running sum over the last 2^WIN_LOG2 accepted samples.
- Compares the sum against a programmable threshold and outputs the energy value, a valid strobe and a detect flag for the decision/report stage.

Parameters:
- DATA_W, 8, sample width (two's complement).
- WIN_LOG2, 4, log2 of window length (window = 16 samples); legal range 1..8.
- SQ_W, 2*DATA_W-1, squared-sample width (localparam); 15 bits holds (-128)^2 = 16384.
- ACC_W, SQ_W+WIN_LOG2, accumulator width (localparam); 19 bits by default.

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high; clears all state.
- enb  in  1  global clock enable; when low, every register holds.
- din  in  DATA_W  signed sample from flip_t.
- din_vld  in  1  sample qualifier; a sample is accepted on a cycle with enb && din_vld.
- thresh  in  ACC_W  unsigned detect threshold; sampled every accepting cycle.
- energy_out  out  ACC_W  current window energy sum.
- energy_vld  out  1  one-cycle strobe; energy_out and detect are updated on this cycle.
- detect  out  1  high when the last reported energy is greater than thresh.
- win_full  out  1  high once the window has filled after reset.

Behaviour:
- Interface (already decided): one clock, clk; reset is synchronous and active-high, port name reset. Reset values: energy_out=0, energy_vld=0, detect=0, win_full=0.
- Reset also clears the write pointer, fill counter, running sum and pipeline valids. Window buffer contents are not cleared.
- enb=0 freezes the whole pipeline, including energy_vld. A strobe pending in a stage is delayed, not lost.
- Pipeline stage S1, on accept: sq = din*din (unsigned SQ_W). S1 also registers the accept flag and the buffer read of the oldest square at wr_ptr.
- Pipeline stage S2: sum <= sum + sq - old. During FILL, old is forced to 0, so stale buffer contents never affect the sum.
- Buffer write: sq is written at wr_ptr and wr_ptr increments modulo 2^WIN_LOG2. wr_ptr wraps from 2^WIN_LOG2-1 to 0.
- Latency: energy_vld pulses exactly 2 enabled cycles after the accepting cycle, and only when win_full is high. It gives one strobe per accepted sample.
- FSM has two states:
  - FILL: counts accepted samples. On the 2^WIN_LOG2-th accept, go to RUN. win_full rises with the first energy_vld.
  - RUN: steady state. Leaves only on reset.
- detect is registered together with energy_vld: detect <= (new_sum > thresh). Equality does not detect. detect holds its value between strobes.
- Arithmetic: the sum never exceeds 2^WIN_LOG2 * 16384, which fits in ACC_W. No saturation logic is required.
- Back-to-back accepts every cycle are supported at full rate.
- Read and write of the same buffer address in one cycle must return the old data (read-before-write).
- Reset mid-window: the next window restarts from empty. No energy_vld appears until 2^WIN_LOG2 new samples have been accepted.
- reset has priority over enb.

Optional Feature:
- Macro: ENERGY_DET_HYST_EN.
- Defined: adds input thresh_lo[ACC_W]. detect sets when sum > thresh and clears only when sum < thresh_lo; it holds in between.
- Not defined: no thresh_lo port; single-threshold compare as above.

Decomposition:
- Package energy_det_pkg holds:
  - DATA_W, WIN_LOG2, SQ_W and ACC_W defaults;
  - an FSM state typedef {FILL, RUN};
  - a sample_t typedef (signed DATA_W) and an energy_t typedef (ACC_W).
- One sub-module: energy_win_buf, a 2^WIN_LOG2 x SQ_W circular buffer with a registered read-before-write port. It is inferable as distributed RAM.

Test Plan:
- Fill: reset, then 16 accepts of din=8'sd3 -> first energy_vld 2 cycles after the 16th accept; energy_out=144, win_full=1; no earlier strobes.
- Slide: continue with din=-8'sd128 for 16 samples -> energy_out rises by 16375 per strobe; final value 262144; no overflow.
- Threshold edge: thresh=144 with steady energy 144 -> detect=0; thresh=143 -> detect=1 on the next strobe.
- Stall: toggle enb low for 5 cycles mid-pipeline -> outputs hold; the strobe arrives 2 enabled cycles after its accept; sum is unchanged versus the unstalled reference.
- Gaps: din_vld on alternate cycles -> exactly one strobe per accepted sample; energy matches a model of the last 16 accepted squares.
- Reset mid-window: reset after 9 samples in RUN -> all outputs 0; the next strobe comes only after 16 fresh accepts, and the old buffer data has no effect. Under ENERGY_DET_HYST_EN, with thresh=200 and thresh_lo=100, energies 250, 150, 90 give detect = 1, 1, 0.
